// File: rtl/serial_parity_pkg.sv
// Items shared by the serial parity transmitter and detector: FSM states,
// parity-mode constants and the parity helper.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StData   = 2'b01,
        StParity = 2'b10
    } state_e;

    localparam int unsigned PARITY_EVEN = 0;
    localparam int unsigned PARITY_ODD  = 1;

    // Widest word the parity helper handles; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int unsigned MaxDataW = 64;

    // Parity bit that makes (data ones + parity bit) even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [MaxDataW-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, shift-right register. Load has priority over shift; the LSB
// is the bit that leaves the register next.
module piso_shifter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              lsb_o
);

    logic [DATA_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_i) begin
            q <= data_i;
        end else if (shift_i) begin
            q <= {1'b0, q[DATA_W-1:1]};
        end
    end

    assign lsb_o = q[0];

endmodule

// File: rtl/serial_parity_transmitter.sv
// Parallel-to-serial transmitter: shifts a word out LSB-first and appends one
// parity bit per frame. Accepting during the parity cycle gives a gapless stream.
module serial_parity_transmitter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              x,
    output logic              x_valid,
    output logic              done
);
    import serial_parity_pkg::*;

    localparam int unsigned    CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
    localparam logic           OddMode = (PARITY_ODD != PARITY_EVEN);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            parity_q;
    logic            x_q;
    logic            x_valid_q;
    logic            done_q;

    logic            accept;
    logic            last_bit;
    logic            new_parity;
    logic            next_bit;

    assign ready      = (state_q == StIdle) || (state_q == StParity);
    assign accept     = valid && ready;
    assign last_bit   = (cnt_q == LastBit);
    assign new_parity = parity_bit(MaxDataW'(data_in), OddMode);

    // Bit 0 goes straight to the output register on accept, so the shifter only
    // holds bits 1..DATA_W-1 and its LSB is always the next bit to send.
    piso_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (state_q == StData),
        .data_i  ({1'b0, data_in[DATA_W-1:1]}),
        .lsb_o   (next_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            parity_q  <= 1'b0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StParity: begin
                    if (accept) begin
                        state_q   <= StData;
                        cnt_q     <= '0;
                        parity_q  <= new_parity;
                        x_q       <= data_in[0];
                        x_valid_q <= 1'b1;
                        done_q    <= 1'b0;
                    end else begin
                        state_q   <= StIdle;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                StData: begin
                    x_valid_q <= 1'b1;
                    if (last_bit) begin
                        state_q <= StParity;
                        x_q     <= parity_q;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        x_q    <= next_bit;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serial_parity_transmitter.sv
// Scoreboard bench: even- and odd-parity transmitters share one input stream;
// accepted words expand into expected serial bits that a negedge monitor checks.
module tb_serial_parity_transmitter;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready_e, x_e, xv_e, done_e;
    logic          ready_o, x_o, xv_o, done_o;

    always #5 clk = ~clk;

    serial_parity_transmitter #(.DATA_W(DW), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready_e), .x(x_e), .x_valid(xv_e), .done(done_e)
    );

    serial_parity_transmitter #(.DATA_W(DW), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready_o), .x(x_o), .x_valid(xv_o), .done(done_o)
    );

    // One entry per expected output cycle; be/bo are the even/odd-mode bits.
    typedef struct packed {
        logic be;
        logic bo;
        logic last;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   run = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: data bits LSB-first, then a bit fixing the ones count.
    function automatic void push_word(input logic [DW-1:0] d);
        int   ones;
        exp_t e;
        ones = $countones(d);
        for (int i = 0; i < DW; i++) begin
            e.be = d[i];
            e.bo = d[i];
            e.last = 1'b0;
            q.push_back(e);
        end
        e.be = (ones % 2 == 1);
        e.bo = (ones % 2 == 0);
        e.last = 1'b1;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("reset_outputs", {x_e, xv_e, done_e, ready_e, x_o, xv_o, done_o, ready_o},
                  8'b0001_0001);
            run = 0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            check("frame_bit", {xv_e, x_e, done_e, ready_e, xv_o, x_o, done_o, ready_o},
                  {1'b1, e.be, e.last, e.last, 1'b1, e.bo, e.last, e.last});
            run++;
            if (run > max_run) max_run = run;
        end else begin
            check("idle_outputs", {xv_e, x_e, done_e, ready_e, xv_o, x_o, done_o, ready_o},
                  8'b0001_0001);
            run = 0;
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, output logic acc);
        @(negedge clk);
        valid = v;
        data_in = d;
        #1;
        acc = v && ready_e && !rst;
        @(posedge clk);
        if (acc) push_word(d);
    endtask

    task automatic send(input logic [DW-1:0] d);
        logic acc;
        drive(1'b1, d, acc);
        check("send_accept", acc, 1);
        // Random data with valid low while the frame drains.
        repeat (DW + 2) drive(1'b0, DW'($urandom), acc);
    endtask

    initial begin
        logic acc;
        logic got;

        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {ready_e, ready_o, x_e, xv_e, done_e}, 5'b11000);

        // Valid in the first cycle after reset release must be accepted.
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1;
        data_in = 8'hA5;
        #1;
        acc = valid && ready_e;
        @(posedge clk);
        if (acc) push_word(8'hA5);
        check("accept_after_reset", acc, 1);
        repeat (DW + 2) drive(1'b0, 8'h00, acc);

        send(8'h07);
        send(8'h00);
        send(8'hFF);

        // Back-to-back with valid held high: 18 consecutive x_valid cycles.
        max_run = 0;
        drive(1'b1, 8'h01, acc);
        check("b2b_first_accept", acc, 1);
        got = 1'b0;
        for (int i = 0; i < DW + 4 && !got; i++) begin
            drive(1'b1, 8'h80, acc);
            got = acc;
        end
        check("b2b_second_accept", got, 1);
        repeat (DW + 3) drive(1'b0, 8'h00, acc);
        check("b2b_run_length", max_run, 2 * (DW + 1));

        // Reset during bit 3 aborts the frame without waiting for an edge.
        drive(1'b1, 8'h5A, acc);
        check("abort_accept", acc, 1);
        repeat (3) drive(1'b0, DW'($urandom), acc);
        #2;
        rst = 1'b1;
        #1;
        check("async_abort", {x_e, xv_e, ready_e, x_o, xv_o, ready_o}, 6'b001001);
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(8'h3C);

        // Busy-input isolation and random traffic.
        repeat (400) drive(1'($urandom_range(0, 1)), DW'($urandom), acc);
        repeat (DW + 3) drive(1'b0, 8'h00, acc);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_parity_transmitter.md
# serial_parity_transmitter

Transmit-side counterpart to the serial parity detector. Accepts a parallel data word through a valid/ready handshake, shifts it out LSB-first on a single serial line, and appends one parity bit per frame. Sits between the parallel producer and the serial link; the receiving detector sees an even count of ones per frame in even mode and an odd count in odd mode.

## Interface
- `DATA_W`: default 8. Data bits per frame; must be at least 2.
- `PARITY_ODD`: default 0. Selects the parity mode.
  - 0: even parity. Ones across data plus parity bit are even.
  - 1: odd parity. Ones across data plus parity bit are odd.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `data_in`: input, `DATA_W` bits. Parallel word to transmit.
- `valid`: input, 1 bit. Producer presents `data_in`.
- `ready`: output, 1 bit. Block can accept a word this cycle.
- `x`: output, 1 bit. Serial data out, registered.
- `x_valid`: output, 1 bit. `x` carries a frame bit this cycle, registered.
- `done`: output, 1 bit. One-cycle pulse, registered, coincident with the parity bit on `x`.

## Operation
- **States:** IDLE, DATA, PARITY.
- **Accept condition:** `valid && ready` at a rising edge.
  - Captures `data_in` into the shift register.
  - Computes parity: `^data_in` when `PARITY_ODD`=0, `~^data_in` when `PARITY_ODD`=1.
  - Clears the bit counter and moves to DATA.
- **DATA state:**
  - Each cycle, `x` carries the current LSB of the shift register and `x_valid`=1.
  - The register shifts right and the counter increments.
  - After bit `DATA_W-1`, moves to PARITY.
- **PARITY state:** `x` = stored parity bit, `x_valid`=1, `done`=1.
  - If an accept occurs in this cycle, next state is DATA, giving a gapless back-to-back stream.
  - Otherwise next state is IDLE.
- **IDLE state:** `x`=0, `x_valid`=0, `done`=0.
- **`ready`:** combinational from state. Equals 1 in IDLE and PARITY, 0 in DATA.
- **Input sampling:** `data_in` and `valid` are ignored while `ready`=0. Changes to `data_in` during DATA do not affect the frame in flight.
- **Illegal state encoding:** forces IDLE on the next edge.
- **Counter width:** `$clog2(DATA_W)` bits. Never wraps within a frame; the DATA→PARITY compare is against `DATA_W-1`.

## Timing
- **Reset values:**
  - State = IDLE.
  - `x`=0, `x_valid`=0, `done`=0.
  - `ready`=1 while and after `rst` is high.
  - Shift register, parity register and counter = 0.
- **Reset mid-frame:** asynchronously aborts the frame. Outputs take reset values immediately, and no `done` is produced for the aborted word.
- **Latency:** accept at edge N gives the following output positions.
  - Bit 0 is on `x` during cycle N+1.
  - Bit k is on `x` during cycle N+1+k.
  - The parity bit is on `x` during cycle N+1+`DATA_W`, with `done`=1.
- **Frame length:** `DATA_W`+1 cycles.
- **Throughput:** with `valid` held high, one word every `DATA_W`+1 cycles and `x_valid` continuously 1.
- **Back-to-back accept:** an accept during PARITY does not disturb the parity bit currently on `x`. Bit 0 of the new word appears on the next cycle.
- **Reset release:** `valid` high in the first cycle after `rst` falls is accepted normally.

## Structure
- **Shared package `serial_parity_pkg`** holds items common to transmitter and detector:
  - State enum (IDLE, DATA, PARITY).
  - `PARITY_EVEN`=0 and `PARITY_ODD`=1 constants.
  - A parity-function helper.
- **Sub-module `piso_shifter`** (parameterised by `DATA_W`): parallel-load, shift-right register with a load/shift enable.
- **Top level** keeps the FSM, counter, parity register and output registers.

## Test plan
- **Even parity, 8'hA5:** accept, then `x` = 1,0,1,0,0,1,0,1 on cycles N+1..N+8. Parity 0 at N+9 with `done`=1, then `x_valid`=0 and `ready`=1.
- **Even parity, 8'h07:** `x` = 1,1,1,0,0,0,0,0, then parity 1.
- **`PARITY_ODD`=1, 8'h00:** eight 0 bits, then parity 1. Repeat with 8'hFF: eight 1 bits, then parity 1.
- **Back-to-back 8'h01 then 8'h80 with `valid` held high:** `x_valid`=1 for 18 consecutive cycles. Stream is 1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,1,1, and `done` pulses at cycles 9 and 18.
- **Reset mid-frame:** assert `rst` in the cycle carrying bit 3. Required response:
  - `x`=0, `x_valid`=0 and `ready`=1 without waiting for a clock edge.
  - No `done` pulse.
  - Next accepted word 8'h3C transmits completely and correctly.
- **Busy-input isolation:** change `data_in` every cycle and toggle `valid` during DATA. The transmitted frame matches the word captured at accept, and no extra accepts occur.
